// File: rtl/avr_irq_ctrl.sv
// rtl/avr_irq_ctrl.sv - fixed-priority interrupt controller, initiator end of the peripheral irq handshake
module avr_irq_ctrl #(
    parameter int NSRC  = 8,
    parameter int VEC_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  irq_req,
    input  logic             sreg_i,
    output logic [NSRC-1:0]  irq_exec,
    output logic             cpu_irq,
    output logic [VEC_W-1:0] cpu_vector,
    input  logic             cpu_ack,
    input  logic             cpu_reti,
    output logic             in_service
);

    localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   arb_idx;
    logic [NSRC-1:0]    irq_exec_q, irq_exec_d;
    logic               cpu_irq_q, cpu_irq_d;
    logic [VEC_W-1:0]   cpu_vector_q, cpu_vector_d;
    logic               in_service_q, in_service_d;

    // Fixed-priority arbiter: lowest set request index wins
    always_comb begin
        arb_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (irq_req[i]) begin
                arb_idx = SEL_W'(i);
            end
        end
    end

    // State and latched source register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic; the selection is frozen once PEND is entered
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (sreg_i && (irq_req != '0)) begin
                    state_d = PEND;
                    sel_d   = arb_idx;
                end
            end
            PEND: begin
                // An accept in the same cycle as a withdrawal still wins
                if (cpu_ack) begin
                    state_d = SERVICE;
                end else if (!irq_req[sel_q] || !sreg_i) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (cpu_reti) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Core runs one instruction after RETI before we may interrupt again
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        cpu_irq_d    = (state_d == PEND);
        in_service_d = (state_d == SERVICE) || (state_d == HOLD);
        irq_exec_d   = '0;
        if ((state_q == PEND) && (state_d == SERVICE)) begin
            irq_exec_d[sel_q] = 1'b1;
        end
        cpu_vector_d = cpu_vector_q;
        if (state_d == PEND) begin
            cpu_vector_d = VEC_W'(sel_d) + VEC_W'(1);
        end
    end

    // Registered outputs; reset clears an in-flight exec pulse too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_exec_q   <= '0;
            cpu_irq_q    <= 1'b0;
            cpu_vector_q <= '0;
            in_service_q <= 1'b0;
        end else begin
            irq_exec_q   <= irq_exec_d;
            cpu_irq_q    <= cpu_irq_d;
            cpu_vector_q <= cpu_vector_d;
            in_service_q <= in_service_d;
        end
    end

    assign irq_exec   = irq_exec_q;
    assign cpu_irq    = cpu_irq_q;
    assign cpu_vector = cpu_vector_q;
    assign in_service = in_service_q;

endmodule
